// File: rtl/calc_display_driver.sv
// calc_display_driver
// -------------------
// Output stage of the calculator. It watches the core's result (Y, sinal, EN).
// When any of those changes, it converts the magnitude to BCD with a
// double-dabble engine that handles one bit per clock. It then drives five
// active-low 7-segment displays: four magnitude digits and one sign digit.
//
// Display behaviour:
//   - Leading zeros are blanked.
//   - Magnitudes above MAX_VAL show dashes on every magnitude digit.
//   - Everything is blank while the calculator is off (EN = 0).
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   Y      in   [W-1:0] result magnitude
//   sinal  in   1 = result is negative
//   EN     in   1 = calculator on, 0 = all displays blank
//   HEX0   out  [6:0] units digit, active-low, bit6..bit0 = g..a
//   HEX1   out  [6:0] tens digit
//   HEX2   out  [6:0] hundreds digit
//   HEX3   out  [6:0] thousands digit
//   HEX4   out  [6:0] sign digit
//   busy   out  high while a conversion is in progress

module calc_display_driver #(
    parameter int W       = 14,
    parameter int NDIG    = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] Y,
    input  logic         sinal,
    input  logic         EN,
    output logic [6:0]   HEX0,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX3,
    output logic [6:0]   HEX4,
    output logic         busy
);

    localparam int BCDW = 4 * NDIG;
    localparam int CNTW = $clog2(W + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t                 state_q, state_d;
    logic                   shadowEn_q, shadowEn_d;
    logic                   shadowSign_q, shadowSign_d;
    logic [W-1:0]           shadowY_q, shadowY_d;
    logic [W-1:0]           bin_q, bin_d;
    logic [BCDW-1:0]        bcd_q, bcd_d;
    logic [CNTW-1:0]        bitCnt_q, bitCnt_d;
    logic                   busy_q, busy_d;
    logic [NDIG:0][6:0]     hex_q, hex_d;

    logic [BCDW-1:0]        bcdAdj;
    logic [BCDW+W-1:0]      shiftVec;
    logic [NDIG:0][6:0]     hexLoad;
    logic                   inputsChanged;

    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    assign inputsChanged = ({EN, sinal, Y} != {shadowEn_q, shadowSign_q, shadowY_q});

    // Double-dabble step: correct every nibble that would overflow past 9 after doubling,
    // then shift the binary MSB into the BCD register.
    always_comb begin
        bcdAdj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shiftVec = {bcdAdj, bin_q} << 1;
    end

    // Display image built from the shadow copy and the finished BCD value.
    // The BCD register only holds NDIG digits. Values past MAX_VAL lose their top
    // digits, but those values take the overflow branch, so this never matters.
    always_comb begin
        logic       leading;
        logic [3:0] digit;
        hexLoad = {(NDIG + 1){SEG_BLANK}};
        leading = 1'b1;
        digit   = 4'd0;
        if (!shadowEn_q) begin
            hexLoad = {(NDIG + 1){SEG_BLANK}};
        end else if (shadowY_q > W'(MAX_VAL)) begin
            for (int i = 0; i < NDIG; i++) begin
                hexLoad[i] = SEG_DASH;
            end
            hexLoad[NDIG] = SEG_BLANK;
        end else begin
            for (int i = NDIG - 1; i >= 1; i--) begin
                digit = bcd_q[4*i +: 4];
                if (leading && (digit == 4'd0)) begin
                    hexLoad[i] = SEG_BLANK;
                end else begin
                    leading    = 1'b0;
                    hexLoad[i] = segDecode(digit);
                end
            end
            // The units digit always shows, so a zero result displays as "0".
            hexLoad[0]    = segDecode(bcd_q[3:0]);
            hexLoad[NDIG] = (shadowSign_q && (shadowY_q != '0)) ? SEG_DASH : SEG_BLANK;
        end
    end

    always_comb begin
        state_d      = state_q;
        shadowEn_d   = shadowEn_q;
        shadowSign_d = shadowSign_q;
        shadowY_d    = shadowY_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        bitCnt_d     = bitCnt_q;
        busy_d       = busy_q;
        hex_d        = hex_q;

        case (state_q)
            IDLE: begin
                if (inputsChanged) begin
                    shadowEn_d   = EN;
                    shadowSign_d = sinal;
                    shadowY_d    = Y;
                    bin_d        = Y;
                    bcd_d        = '0;
                    bitCnt_d     = '0;
                    busy_d       = 1'b1;
                    state_d      = CONV;
                end
            end
            CONV: begin
                bcd_d    = shiftVec[BCDW+W-1:W];
                bin_d    = shiftVec[W-1:0];
                bitCnt_d = bitCnt_q + CNTW'(1);
                if (bitCnt_q == CNTW'(W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hex_d   = hexLoad;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadowEn_q   <= 1'b0;
            shadowSign_q <= 1'b0;
            shadowY_q    <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            bitCnt_q     <= '0;
            busy_q       <= 1'b0;
            hex_q        <= {(NDIG + 1){SEG_BLANK}};
        end else begin
            state_q      <= state_d;
            shadowEn_q   <= shadowEn_d;
            shadowSign_q <= shadowSign_d;
            shadowY_q    <= shadowY_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            bitCnt_q     <= bitCnt_d;
            busy_q       <= busy_d;
            hex_q        <= hex_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[NDIG];
    assign busy = busy_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver
// ----------------------
// Self-checking bench for calc_display_driver.
//
// The stimulus side applies directed input vectors. For each vector it queues
// the hand-computed display image. A separate monitor pops one entry each time
// busy falls and compares all five digits against it.

module tb_calc_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] DA = 7'b0111111;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] Y = '0;
    logic        sinal = 1'b0;
    logic        EN = 1'b0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;
    logic        busy;

    typedef struct {
        string      name;
        logic [6:0] h4, h3, h2, h1, h0;
    } exp_t;

    exp_t scoreQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    calc_display_driver #(
        .W(14),
        .NDIG(4),
        .MAX_VAL(9999)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Y(Y),
        .sinal(sinal),
        .EN(EN),
        .HEX0(HEX0),
        .HEX1(HEX1),
        .HEX2(HEX2),
        .HEX3(HEX3),
        .HEX4(HEX4),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input string name, input logic [6:0] h4, input logic [6:0] h3,
                           input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
        exp_t e;
        e.name = name;
        e.h4 = h4;
        e.h3 = h3;
        e.h2 = h2;
        e.h1 = h1;
        e.h0 = h0;
        scoreQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic en, input logic sg, input logic [13:0] y);
        @(negedge clk);
        #1;
        EN    = en;
        sinal = sg;
        Y     = y;
    endtask

    task automatic waitConv(input int startCnt, input string name);
        int cnt;
        bit done;
        cnt  = startCnt;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
            end else if (cnt > 0) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s timeout: busy never completed, got %0d cycles", name, cnt);
        end else begin
            checkOutput({name, " busy cycles"}, cnt, 15);
        end
    endtask

    // Monitor: each falling edge of busy marks a display update.
    initial begin
        logic busyPrev;
        exp_t e;
        busyPrev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busyPrev = 1'b0;
            end else begin
                if (busyPrev && !busy) begin
                    if (scoreQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpected update: got HEX4..0 %h %h %h %h %h, expected none",
                                 HEX4, HEX3, HEX2, HEX1, HEX0);
                    end else begin
                        e = scoreQ.pop_front();
                        checkOutput({e.name, " HEX4"}, HEX4, e.h4);
                        checkOutput({e.name, " HEX3"}, HEX3, e.h3);
                        checkOutput({e.name, " HEX2"}, HEX2, e.h2);
                        checkOutput({e.name, " HEX1"}, HEX1, e.h1);
                        checkOutput({e.name, " HEX0"}, HEX0, e.h0);
                    end
                end
                busyPrev = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state with the calculator off.
        #12;
        checkOutput("reset HEX0", HEX0, BL);
        checkOutput("reset HEX1", HEX1, BL);
        checkOutput("reset HEX2", HEX2, BL);
        checkOutput("reset HEX3", HEX3, BL);
        checkOutput("reset HEX4", HEX4, BL);
        checkOutput("reset busy", busy, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle after reset busy", busy, 0);
        checkOutput("idle after reset HEX0", HEX0, BL);

        pushExp("9801", BL, S9, S8, S0, S1);
        applyStimulus(1'b1, 1'b0, 14'd9801);
        waitConv(0, "9801");

        pushExp("42", BL, BL, BL, S4, S2);
        applyStimulus(1'b1, 1'b0, 14'd42);
        waitConv(0, "42");

        pushExp("0 pos", BL, BL, BL, BL, S0);
        applyStimulus(1'b1, 1'b0, 14'd0);
        waitConv(0, "0 pos");

        pushExp("-57", DA, BL, BL, S5, S7);
        applyStimulus(1'b1, 1'b1, 14'd57);
        waitConv(0, "-57");

        pushExp("0 neg", BL, BL, BL, BL, S0);
        applyStimulus(1'b1, 1'b1, 14'd0);
        waitConv(0, "0 neg");

        pushExp("305", BL, BL, S3, S0, S5);
        applyStimulus(1'b1, 1'b0, 14'd305);
        waitConv(0, "305");

        pushExp("-9999", DA, S9, S9, S9, S9);
        applyStimulus(1'b1, 1'b1, 14'd9999);
        waitConv(0, "-9999");

        pushExp("-10000 ovf", BL, DA, DA, DA, DA);
        applyStimulus(1'b1, 1'b1, 14'd10000);
        waitConv(0, "-10000 ovf");

        pushExp("12000 ovf", BL, DA, DA, DA, DA);
        applyStimulus(1'b1, 1'b0, 14'd12000);
        waitConv(0, "12000 ovf");

        pushExp("EN off", BL, BL, BL, BL, BL);
        applyStimulus(1'b0, 1'b0, 14'd12000);
        waitConv(0, "EN off");

        // Input change during a conversion is deferred to a second conversion.
        pushExp("100", BL, BL, S1, S0, S0);
        pushExp("250", BL, BL, S2, S5, S0);
        applyStimulus(1'b1, 1'b0, 14'd100);
        repeat (3) @(negedge clk);
        #1 Y = 14'd250;
        waitConv(3, "100");
        @(negedge clk);
        checkOutput("restart after one idle cycle", busy, 1);
        waitConv(1, "250");

        // Reset mid-conversion aborts and blanks immediately.
        applyStimulus(1'b1, 1'b0, 14'd33);
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort HEX0", HEX0, BL);
        checkOutput("abort HEX1", HEX1, BL);
        checkOutput("abort HEX2", HEX2, BL);
        checkOutput("abort HEX3", HEX3, BL);
        checkOutput("abort HEX4", HEX4, BL);
        checkOutput("abort busy", busy, 0);
        pushExp("33 after reset", BL, BL, BL, S3, S3);
        @(negedge clk);
        #1 rst_n = 1'b1;
        waitConv(0, "33 after reset");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", scoreQ.size(), 0);
        checkOutput("final busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
